// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter with a registered broadcast stage.
// Optional perf_bcast/perf_conflict counters when CDB_PERF_CNT_EN is defined.
module cdb_arbiter #(
  parameter int                NUM_FU      = 4,
  parameter int                DATA_W      = 32,
  parameter int                TAG_W       = 6,
  parameter logic [TAG_W-1:0]  INVALID_TAG = 6'b010000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_FU-1:0]        req_valid,
  input  logic [NUM_FU*TAG_W-1:0]  req_tag,
  input  logic [NUM_FU*DATA_W-1:0] req_data,
  output logic [NUM_FU-1:0]        req_ready,
  input  logic                     cdb_hold,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [2:0]               cdb_src,
  output logic                     bad_tag
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_bcast,
  output logic [31:0]              perf_conflict
`endif
);

  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [2:0]        cdb_src_q, cdb_src_d;
  logic              bad_tag_q, bad_tag_d;

  logic              grant_found;
  logic [2:0]        grant_idx;
  logic              xfer;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  logic              win_bad;
  logic [2:0]        next_ptr;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    for (int k = 0; k < NUM_FU; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_FU;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = 3'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found && !cdb_hold && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer     = |(req_valid & req_ready);
  assign win_tag  = req_tag[int'(grant_idx)*TAG_W +: TAG_W];
  assign win_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign win_bad  = (win_tag == INVALID_TAG) || (32'(win_tag) >= 32'd16);
  assign next_ptr = (int'(grant_idx) == NUM_FU - 1) ? 3'd0 : grant_idx + 3'd1;

  // Bad tags are consumed and advance the pointer but never reach the bus.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = INVALID_TAG;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    bad_tag_d   = bad_tag_q;
    if (xfer) begin
      rr_ptr_d = next_ptr;
      if (win_bad) begin
        bad_tag_d = 1'b1;
      end else begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = win_tag;
        cdb_data_d  = win_data;
        cdb_src_d   = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= 3'd0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= INVALID_TAG;
      cdb_data_q  <= '0;
      cdb_src_q   <= 3'd0;
      bad_tag_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      bad_tag_q   <= bad_tag_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign bad_tag   = bad_tag_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_bcast_q, perf_bcast_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [3:0]  req_cnt;

  always_comb begin
    req_cnt = 4'd0;
    for (int i = 0; i < NUM_FU; i++) begin
      req_cnt = req_cnt + {3'd0, req_valid[i]};
    end
  end

  always_comb begin
    perf_bcast_d    = perf_bcast_q;
    perf_conflict_d = perf_conflict_q;
    if (xfer && !win_bad) begin
      perf_bcast_d = perf_bcast_q + 32'd1;
    end
    if (xfer && (req_cnt >= 4'd2)) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bcast_q    <= 32'd0;
      perf_conflict_q <= 32'd0;
    end else begin
      perf_bcast_q    <= perf_bcast_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_bcast    = perf_bcast_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed checks of cdb_arbiter arbitration, latency, hold, reset and tag screening.
module tb_cdb_arbiter;
  localparam int NUM_FU = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_FU-1:0]        req_valid;
  logic [NUM_FU*TAG_W-1:0]  req_tag;
  logic [NUM_FU*DATA_W-1:0] req_data;
  logic [NUM_FU-1:0]        req_ready;
  logic                     cdb_hold;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [2:0]               cdb_src;
  logic                     bad_tag;
`ifdef CDB_PERF_CNT_EN
  logic [31:0]              perf_bcast;
  logic [31:0]              perf_conflict;
`endif

  int n_vec = 0;
  int n_err = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .cdb_hold(cdb_hold),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .bad_tag(bad_tag)
`ifdef CDB_PERF_CNT_EN
    , .perf_bcast(perf_bcast), .perf_conflict(perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_tag = '0; req_data = '0; cdb_hold = 1'b0;
    req_valid = 4'b1111;
    #12;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_valid", 64'(cdb_valid), 64'h0);
    check("rst_tag",   64'(cdb_tag),   64'd16);
    check("rst_data",  64'(cdb_data),  64'h0);
    check("rst_src",   64'(cdb_src),   64'h0);
    check("rst_bad",   64'(bad_tag),   64'h0);
    req_valid = '0;
    tick();
    rst = 1'b0;

    // Reset mid-broadcast.
    set_fu(1, 6'd3, 32'h1111);
    req_valid = 4'b0010;
    #1 check("t1_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    check("t1_valid", 64'(cdb_valid), 64'h1);
    check("t1_tag",   64'(cdb_tag),   64'd3);
    check("t1_src",   64'(cdb_src),   64'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_valid", 64'(cdb_valid), 64'h0);
    check("t1_rst_tag",   64'(cdb_tag),   64'd16);
    check("t1_rst_src",   64'(cdb_src),   64'd0);
    tick();
    rst = 1'b0;

    // Single FU0 broadcast and return to idle.
    set_fu(0, 6'd5, 32'hDEAD);
    req_valid = 4'b0001;
    #1 check("t2_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    check("t2_valid", 64'(cdb_valid), 64'h1);
    check("t2_tag",   64'(cdb_tag),   64'd5);
    check("t2_data",  64'(cdb_data),  64'hDEAD);
    check("t2_src",   64'(cdb_src),   64'd0);
    tick();
    check("t2_idle_valid", 64'(cdb_valid), 64'h0);
    check("t2_idle_tag",   64'(cdb_tag),   64'd16);
    check("t2_idle_data",  64'(cdb_data),  64'hDEAD);

    // Re-reset to bring rr_ptr back to 0, then all four FUs compete.
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 6'(4 + i), 32'(32'h100 + i));
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 check($sformatf("t3_ready_%0d", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
      tick();
      check($sformatf("t3_src_%0d", c), 64'(cdb_src),  64'(c % 4));
      check($sformatf("t3_tag_%0d", c), 64'(cdb_tag),  64'(4 + c % 4));
      check($sformatf("t3_dat_%0d", c), 64'(cdb_data), 64'(32'h100 + c % 4));
    end
    req_valid = '0;
`ifdef CDB_PERF_CNT_EN
    check("t6_bcast",    64'(perf_bcast),    64'd8);
    check("t6_conflict", 64'(perf_conflict), 64'd8);
`endif
    tick();

    // Hold blocks grants; FU2 wins first on release.
    req_valid = 4'b1100;
    cdb_hold  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("t4_hold_ready_%0d", c), 64'(req_ready), 64'h0);
      tick();
      check($sformatf("t4_hold_valid_%0d", c), 64'(cdb_valid), 64'h0);
    end
    cdb_hold = 1'b0;
    #1 check("t4_rel_ready", 64'(req_ready), 64'b0100);
    tick();
    check("t4_rel_src", 64'(cdb_src), 64'd2);
    #1 check("t4_next_ready", 64'(req_ready), 64'b1000);
    tick();
    check("t4_next_src", 64'(cdb_src), 64'd3);
    req_valid = '0;
    tick();

    // Tag 16 is consumed without broadcast and sets sticky bad_tag.
    set_fu(1, 6'd16, 32'hBAD0);
    req_valid = 4'b0010;
    #1 check("t5_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'b0101;
    check("t5_valid", 64'(cdb_valid), 64'h0);
    check("t5_tag",   64'(cdb_tag),   64'd16);
    check("t5_data",  64'(cdb_data),  64'h103);
    check("t5_bad",   64'(bad_tag),   64'h1);
    #1 check("t5_ptr_adv_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    check("t5_after_src", 64'(cdb_src), 64'd2);
    tick();
    check("t5_bad_sticky", 64'(bad_tag), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
